// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths
// and peripheral register offsets.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [7:0] LED_CTRL   = 8'h00;
  localparam logic [7:0] BLINK_RATE = 8'h04;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter; expired flags the LIMIT-th wait cycle.
// Only instantiated when APB_MST_TIMEOUT_EN is defined.
module apb_timeout_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // count ACCESS cycles, saturating once the limit is hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: cmd stream in, rsp stream out.
// Optional ACCESS timeout abort under APB_MST_TIMEOUT_EN.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              perr
);

  apb_state_e state;
  logic       to_expired;

`ifdef APB_MST_TIMEOUT_EN
  apb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_to (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != ST_ACCESS),
    .enable  (state == ST_ACCESS),
    .expired (to_expired)
  );
`else
  // ACCESS waits indefinitely; the comparison folds to constant 0
  assign to_expired = (TIMEOUT_CYCLES < 0);
`endif

  // transfer FSM with registered APB and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            paddr     <= cmd_addr;
            pwrite    <= cmd_write;
            pwdata    <= cmd_wdata;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= perr;
            rsp_timeout <= 1'b0;
            state       <= ST_RESP;
          end else if (to_expired) begin
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            pwrite    <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a small blink-rate slave.
// Define APB_MST_TIMEOUT_EN to exercise the timeout abort path.
module tb_apb_cmd_master;
  import apb_pkg::*;

`ifdef APB_MST_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        perr;

  int checks   = 0;
  int failures = 0;

  apb_cmd_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_write   (cmd_write),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .perr        (perr)
  );

  always #5 clk = ~clk;

  // slave model
  int          wait_states = 0;
  logic        stuck       = 1'b0;
  logic        perr_en     = 1'b0;
  logic [15:0] acc_cnt     = '0;
  logic [31:0] blink_reg   = '0;

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 16'd1;
    else acc_cnt <= '0;
    if (psel && penable && pready && pwrite && paddr == 32'(BLINK_RATE))
      blink_reg <= pwdata;
  end

  assign pready = !stuck && (int'(acc_cnt) >= wait_states);
  assign perr   = perr_en;
  assign prdata = pwrite ? 32'hBAD0_0BAD :
                  (paddr == 32'(BLINK_RATE)) ? blink_reg :
                  {16'hC0FF, acc_cnt};

  // bus monitor
  int          psel_cnt   = 0;
  int          pen_cnt    = 0;
  int          stable_err = 0;
  logic [31:0] su_addr, su_wdata;
  logic        su_write;

  always @(negedge clk) begin
    if (rst_n && psel) begin
      psel_cnt <= psel_cnt + 1;
      if (!penable) begin
        su_addr  <= paddr;
        su_wdata <= pwdata;
        su_write <= pwrite;
      end else begin
        pen_cnt <= pen_cnt + 1;
        if (paddr !== su_addr || pwdata !== su_wdata || pwrite !== su_write)
          stable_err <= stable_err + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic w,
                       input logic [31:0] d);
    int n;
    @(negedge clk);
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", cmd_ready, 1);
    psel_cnt   = 0;
    pen_cnt    = 0;
    stable_err = 0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, output int lat);
    lat = 1;
    while (!rsp_valid && lat < max) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int lat;
  int bad;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    rst_n = 1'b1;

    // 1: zero-wait write to blink rate
    issue(32'(BLINK_RATE), 1'b1, 32'h0000_0010);
    chk("t1_setup_psel", psel, 1);
    chk("t1_setup_penable", penable, 0);
    wait_rsp(50, lat);
    chk("t1_lat", lat, 3);
    chk("t1_psel_cycles", psel_cnt, 2);
    chk("t1_penable_cycles", pen_cnt, 1);
    chk("t1_stable", stable_err, 0);
    chk("t1_pwdata", su_wdata, 32'h10);
    chk("t1_err", rsp_err, 0);
    chk("t1_rdata", rsp_rdata, 0);
    chk("t1_timeout", rsp_timeout, 0);
    accept();
    chk("t1_idle_ready", cmd_ready, 1);
    chk("t1_idle_pwrite", pwrite, 0);
    chk("t1_idle_paddr", paddr, 32'(BLINK_RATE));
    chk("t1_idle_pwdata", pwdata, 32'h10);

    // 2: read back blink rate
    issue(32'(BLINK_RATE), 1'b0, 32'h0);
    wait_rsp(50, lat);
    chk("t2_lat", lat, 3);
    chk("t2_rdata", rsp_rdata, 32'h10);
    chk("t2_err", rsp_err, 0);
    accept();

    // 3: read with 3 wait states
    wait_states = 3;
    issue(32'h0000_0008, 1'b0, 32'h0);
    wait_rsp(50, lat);
    chk("t3_lat", lat, 6);
    chk("t3_penable_cycles", pen_cnt, 4);
    chk("t3_psel_cycles", psel_cnt, 5);
    chk("t3_stable", stable_err, 0);
    chk("t3_rdata", rsp_rdata, 32'hC0FF_0003);
    accept();
    wait_states = 0;

    // 4: slave error, response backpressure, blocked command
    perr_en = 1'b1;
    issue(32'h0000_000C, 1'b0, 32'h0);
    wait_rsp(50, lat);
    perr_en = 1'b0;
    chk("t4_lat", lat, 3);
    chk("t4_err", rsp_err, 1);
    chk("t4_timeout", rsp_timeout, 0);
    chk("t4_rdata", rsp_rdata, 32'hC0FF_0000);
    cmd_addr  = 32'(BLINK_RATE);
    cmd_write = 1'b1;
    cmd_wdata = 32'h0000_0020;
    cmd_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(rsp_valid && !cmd_ready && !psel && rsp_err)) bad++;
    end
    chk("t4_hold", bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t4_rsp_done", rsp_valid, 0);
    chk("t4_ready_back", cmd_ready, 1);
    chk("t4_not_taken", psel, 0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t4_new_psel", psel, 1);
    chk("t4_new_penable", penable, 0);
    chk("t4_new_pwdata", pwdata, 32'h20);
    wait_rsp(50, lat);
    chk("t4_new_lat", lat, 3);
    chk("t4_new_err", rsp_err, 0);
    accept();

    // 5: slave never ready
    stuck = 1'b1;
    issue(32'h0000_0010, 1'b0, 32'h0);
`ifdef APB_MST_TIMEOUT_EN
    wait_rsp(100, lat);
    chk("t5_lat", lat, 10);
    chk("t5_penable_cycles", pen_cnt, 8);
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_err", rsp_err, 1);
    chk("t5_timeout", rsp_timeout, 1);
    chk("t5_rdata", rsp_rdata, 0);
    accept();
    issue(32'h0000_0010, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    #1;
`else
    wait_rsp(100, lat);
    #1;
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_still_access", penable, 1);
    chk("t5_penable_cycles", pen_cnt, 99);
    chk("t5_timeout", rsp_timeout, 0);
`endif

    // 6: async reset mid-ACCESS
    chk("t6_in_access", psel && penable, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_psel", psel, 0);
    chk("t6_penable", penable, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    stuck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'(BLINK_RATE), 1'b1, 32'h0000_0033);
    wait_rsp(50, lat);
    chk("t6_lat", lat, 3);
    chk("t6_err", rsp_err, 0);
    chk("t6_timeout", rsp_timeout, 0);
    accept();
    issue(32'(BLINK_RATE), 1'b0, 32'h0);
    wait_rsp(50, lat);
    chk("t6_rd_lat", lat, 3);
    chk("t6_rdata", rsp_rdata, 32'h33);
    accept();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
